line_window_ctrl: RTL
=====================

Name: line_window_ctrl

Overview:
- Line-buffer controller and sequencer for the 3x3 sliding-window stage of the HPF filter pipeline.
- Accepts a raster pixel stream and stores lines in a ring of 4 line buffers.
- Once 3 complete lines exist, it replays them column by column as 3-pixel vertical slices (one per cycle) into the window stage's 3*DATA_WIDTH input.
- Handles frame boundaries and input back-pressure.

Parameters:
- IMG_WIDTH, 256, pixels per line (>=4).
- IMG_HEIGHT, 256, lines per frame (>=3).
- DATA_WIDTH, 8, bits per pixel.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- s_data  in  DATA_WIDTH  input pixel, raster order.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  controller can accept a pixel; transfer occurs when s_valid && s_ready.
- m_data  out  3*DATA_WIDTH  column slice: [DW-1:0]=top (oldest) row, [2DW-1:DW]=middle row, [3DW-1:2DW]=bottom (newest) row.
- m_valid  out  1  m_data valid; no back-pressure, drives the window-stage i_valid.
- m_sol  out  1  with m_valid, marks column 0 of a row-set.
- m_eol  out  1  with m_valid, marks column IMG_WIDTH-1 of a row-set.
- frame_done  out  1  one-cycle pulse after the last column of the last row-set of a frame.

Behaviour:
- Reset (rst sampled high at clk edge): clears wr_col, wr_sel, in_row, rd_col, rd_sel, out_row and lines_stored to 0; state goes to RD_IDLE. After reset, m_data=0, m_valid=0, m_sol=0, m_eol=0, frame_done=0. Buffer RAM contents are not cleared. Reset mid-frame discards all partial and stored lines; the next accepted pixel is pixel (0,0) of a new frame.
- Storage: 4 buffers, each IMG_WIDTH x DATA_WIDTH, with a registered (1-cycle) read. lines_stored (0..4) counts complete unread-or-in-use lines.
- s_ready = (lines_stored != 4). This is combinational from registers only, with no dependence on s_valid.
- Write side: each transfer writes buf[wr_sel][wr_col], then wr_col++. When wr_col reaches IMG_WIDTH-1 on a transfer:
  - wr_col goes to 0, wr_sel goes to (wr_sel+1) mod 4, lines_stored increments.
  - in_row increments and wraps to 0 at IMG_HEIGHT-1.
- Read FSM, RD_IDLE:
  - Goes to RD_RUN when lines_stored >= 3. Sets rd_col=0.
- Read FSM, RD_RUN:
  - Each cycle it issues a read at rd_col of buffers rd_sel (top), rd_sel+1 (middle) and rd_sel+2 (bottom), all indices mod 4.
  - rd_col increments every cycle.
  - The issue register pipeline produces m_valid, m_sol and m_eol exactly 1 cycle after issue, aligned with RAM data.
- Last column issue (rd_col = IMG_WIDTH-1):
  - If out_row < IMG_HEIGHT-3: rd_sel += 1, lines_stored -= 1, out_row += 1.
  - Else (final row-set of the frame): rd_sel += 3, lines_stored -= 3, out_row = 0, and frame_done pulses in the cycle m_eol is output.
  - Next state is RD_RUN with rd_col=0 if the post-update lines_stored >= 3; otherwise RD_IDLE. Consecutive row-sets therefore stream with no gap.
- Simultaneous write-line-complete and read-release in the same cycle: lines_stored takes the net change (+1 and -1 or -3), computed in a single update.
- Latency: first m_valid is 3 cycles after the edge accepting the last pixel of line 2 (edge T: lines_stored=3; T+1: RD_RUN entered; T+2: column 0 issued; T+3: m_valid). m_valid stays high for IMG_WIDTH consecutive cycles per row-set. Each frame produces IMG_HEIGHT-2 row-sets.
- Overrun: when all 4 buffers are full, s_ready deasserts until a release. Pixels are never dropped or overwritten.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=4, pixels 0..15 streamed continuously -> first m_valid slices {8,4,0},{9,5,1},{10,6,2},{11,7,3} with m_sol on the first and m_eol on the last. Then {12,8,4}..{15,11,7} back-to-back. frame_done fires with the second m_eol. Exactly 8 m_valid cycles in total.
- Same stimulus, then a second frame of pixels 16..31 without idle -> second frame slices {24,20,16}..{31,27,23}. No frame-1 data leaks into them. lines_stored returns to 0 after the second frame_done.
- IMG_WIDTH=4, s_valid held high -> s_ready drops when lines_stored=4 and rises the cycle after a release. All 16 pixels appear in the outputs in order, with none lost.
- s_valid toggling 1,0,1,0 (gaps) -> output slices identical to the continuous case. m_valid bursts stay contiguous in 4-cycle groups.
- rst asserted for 1 cycle after 6 pixels, then pixels 100..115 sent -> no m_valid before the new third line completes. First slice is {108,104,100}.
- Write completing a line on the same edge as the read's final-column release -> lines_stored changes by the net amount only. Checked with an assertion against a reference count.

Source files
------------

// File: rtl/line_window_ctrl.sv
// -----------------------------------------------------------------------------
// line_window_ctrl
//
// Line-buffer controller and sequencer for the 3x3 sliding-window stage of the
// HPF filter pipeline. Raster pixels are written into a ring of four line
// buffers. Once three complete lines are held, the controller replays them
// column by column as 3-pixel vertical slices, one per cycle, into the window
// stage. When all four buffers are occupied the input is back-pressured until
// the reader releases a line.
//
// Ports:
//   clk         clock
//   rst         synchronous, active-high reset
//   s_data      input pixel, raster order
//   s_valid     input pixel valid
//   s_ready     controller can accept a pixel (transfer on s_valid && s_ready)
//   m_data      column slice {bottom (newest), middle, top (oldest)}
//   m_valid     m_data valid, no back-pressure
//   m_sol       with m_valid: column 0 of a row-set
//   m_eol       with m_valid: column IMG_WIDTH-1 of a row-set
//   frame_done  pulse together with the last m_eol of a frame
//
// Read FSM:
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   RD_IDLE | fewer than three complete lines held, nothing issued
//   RD_RUN  | issuing one column read per cycle across three buffers
// -----------------------------------------------------------------------------
module line_window_ctrl #(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256,
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [3*DATA_WIDTH-1:0]   m_data,
    output logic                      m_valid,
    output logic                      m_sol,
    output logic                      m_eol,
    output logic                      frame_done
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_FINAL_SET = RW'(IMG_HEIGHT - 3);

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RUN  = 1'b1
    } rd_state_t;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    rd_state_t       state_q, state_d;

    logic [CW-1:0]   wr_col_q, wr_col_d;
    logic [1:0]      wr_sel_q, wr_sel_d;
    logic [RW-1:0]   in_row_q, in_row_d;

    logic [CW-1:0]   rd_col_q, rd_col_d;
    logic [1:0]      rd_sel_q, rd_sel_d;
    logic [RW-1:0]   out_row_q, out_row_d;

    logic [2:0]      lines_stored_q, lines_stored_d;

    // Issue stage: address and flags of the column being read this cycle.
    logic            iss_valid_q, iss_valid_d;
    logic [CW-1:0]   iss_col_q, iss_col_d;
    logic [1:0]      iss_sel_q, iss_sel_d;
    logic            iss_sol_q, iss_sol_d;
    logic            iss_eol_q, iss_eol_d;
    logic            iss_last_q, iss_last_d;

    // Output stage, aligned with the registered RAM read data.
    logic            m_valid_q, m_valid_d;
    logic            m_sol_q, m_sol_d;
    logic            m_eol_q, m_eol_d;
    logic            frame_done_q, frame_done_d;

    // -------------------------------------------------------------------------
    // Line buffer storage
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] buf_mem [4][IMG_WIDTH];
    logic [DATA_WIDTH-1:0] ram_top_r, ram_mid_r, ram_bot_r;

    logic [1:0] iss_sel_mid;
    logic [1:0] iss_sel_bot;

    logic       wr_fire;
    logic       wr_line_done;
    logic [2:0] rel_cnt;

    assign s_ready      = (lines_stored_q != 3'd4);
    assign wr_fire      = s_valid && s_ready;
    assign wr_line_done = wr_fire && (wr_col_q == COL_LAST);

    assign iss_sel_mid  = iss_sel_q + 2'd1;
    assign iss_sel_bot  = iss_sel_q + 2'd2;

    // The buffer being written is never one of the three being read: writes
    // are only allowed while fewer than four lines are held, and a released
    // buffer is only rewritten from column 0 after the release edge.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            buf_mem[wr_sel_q][wr_col_q] <= s_data;
        end
        if (iss_valid_q) begin
            ram_top_r <= buf_mem[iss_sel_q][iss_col_q];
            ram_mid_r <= buf_mem[iss_sel_mid][iss_col_q];
            ram_bot_r <= buf_mem[iss_sel_bot][iss_col_q];
        end
    end

    // RAM read registers are not reset, so the output is forced to zero
    // whenever it is not carrying a valid slice.
    assign m_data = m_valid_q ? {ram_bot_r, ram_mid_r, ram_top_r}
                              : {(3*DATA_WIDTH){1'b0}};

    assign m_valid    = m_valid_q;
    assign m_sol      = m_sol_q;
    assign m_eol      = m_eol_q;
    assign frame_done = frame_done_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        wr_col_d       = wr_col_q;
        wr_sel_d       = wr_sel_q;
        in_row_d       = in_row_q;
        rd_col_d       = rd_col_q;
        rd_sel_d       = rd_sel_q;
        out_row_d      = out_row_q;
        lines_stored_d = lines_stored_q;
        rel_cnt        = 3'd0;

        iss_valid_d    = 1'b0;
        iss_col_d      = rd_col_q;
        iss_sel_d      = rd_sel_q;
        iss_sol_d      = 1'b0;
        iss_eol_d      = 1'b0;
        iss_last_d     = 1'b0;

        // Write side
        if (wr_fire) begin
            if (wr_line_done) begin
                wr_col_d = '0;
                wr_sel_d = wr_sel_q + 2'd1;
                in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + 1'b1;
            end else begin
                wr_col_d = wr_col_q + 1'b1;
            end
        end

        // Read side
        case (state_q)
            RD_IDLE: begin
                if (lines_stored_q >= 3'd3) begin
                    state_d  = RD_RUN;
                    rd_col_d = '0;
                end
            end
            RD_RUN: begin
                iss_valid_d = 1'b1;
                iss_sol_d   = (rd_col_q == '0);
                rd_col_d    = rd_col_q + 1'b1;
                if (rd_col_q == COL_LAST) begin
                    iss_eol_d = 1'b1;
                    rd_col_d  = '0;
                    if (out_row_q < ROW_FINAL_SET) begin
                        rd_sel_d  = rd_sel_q + 2'd1;
                        rel_cnt   = 3'd1;
                        out_row_d = out_row_q + 1'b1;
                    end else begin
                        // Final row-set: the last three lines of the frame
                        // are all released together.
                        rd_sel_d   = rd_sel_q + 2'd3;
                        rel_cnt    = 3'd3;
                        out_row_d  = '0;
                        iss_last_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase

        // Single net update so a line completion and a release on the same
        // edge are both accounted for.
        lines_stored_d = lines_stored_q + {2'b00, wr_line_done} - rel_cnt;

        if (state_q == RD_RUN && rd_col_q == COL_LAST) begin
            state_d = (lines_stored_d >= 3'd3) ? RD_RUN : RD_IDLE;
        end

        m_valid_d    = iss_valid_q;
        m_sol_d      = iss_valid_q && iss_sol_q;
        m_eol_d      = iss_valid_q && iss_eol_q;
        frame_done_d = iss_valid_q && iss_eol_q && iss_last_q;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RD_IDLE;
            wr_col_q       <= '0;
            wr_sel_q       <= '0;
            in_row_q       <= '0;
            rd_col_q       <= '0;
            rd_sel_q       <= '0;
            out_row_q      <= '0;
            lines_stored_q <= '0;
            iss_valid_q    <= 1'b0;
            iss_col_q      <= '0;
            iss_sel_q      <= '0;
            iss_sol_q      <= 1'b0;
            iss_eol_q      <= 1'b0;
            iss_last_q     <= 1'b0;
            m_valid_q      <= 1'b0;
            m_sol_q        <= 1'b0;
            m_eol_q        <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_col_q       <= wr_col_d;
            wr_sel_q       <= wr_sel_d;
            in_row_q       <= in_row_d;
            rd_col_q       <= rd_col_d;
            rd_sel_q       <= rd_sel_d;
            out_row_q      <= out_row_d;
            lines_stored_q <= lines_stored_d;
            iss_valid_q    <= iss_valid_d;
            iss_col_q      <= iss_col_d;
            iss_sel_q      <= iss_sel_d;
            iss_sol_q      <= iss_sol_d;
            iss_eol_q      <= iss_eol_d;
            iss_last_q     <= iss_last_d;
            m_valid_q      <= m_valid_d;
            m_sol_q        <= m_sol_d;
            m_eol_q        <= m_eol_d;
            frame_done_q   <= frame_done_d;
        end
    end

endmodule
